// File: rtl/version_consts_pkg.sv
// -----------------------------------------------------------------------------
// version_consts_pkg
// Build identification constants for the running bitstream: semantic version,
// build number and build timestamp. Date/time fields are BCD so they read
// naturally in a hex dump on the host side.
// No ports (package only).
// -----------------------------------------------------------------------------
package version_consts_pkg;

    localparam logic [7:0]  VER_MAJOR    = 8'h00;
    localparam logic [7:0]  VER_MINOR    = 8'h00;
    localparam logic [7:0]  VER_PATCH    = 8'h00;
    localparam logic [7:0]  VER_BUILD    = 8'd64;

    localparam logic [15:0] BUILD_YEAR   = 16'h2025;
    localparam logic [7:0]  BUILD_MONTH  = 8'h11;
    localparam logic [7:0]  BUILD_DAY    = 8'h08;
    localparam logic [7:0]  BUILD_HOUR   = 8'h15;
    localparam logic [7:0]  BUILD_MINUTE = 8'h03;
    localparam logic [7:0]  BUILD_SECOND = 8'h23;

endpackage

// File: rtl/version_info_pkg.sv
// -----------------------------------------------------------------------------
// version_info_pkg
// Shared definitions for the version-info record streamer: record size, byte
// positions inside the 16-byte record, FSM state type, CRC-8 constants, the
// packed record type and a helper that assembles a record for a given
// sequence number (trailer left at 0x00; the streamer fills it in).
// The CRC trailer is only populated when VERSION_INFO_CRC_EN is defined.
// No ports (package only).
// -----------------------------------------------------------------------------
package version_info_pkg;

    import version_consts_pkg::*;

    localparam int RECORD_BYTES  = 16;
    localparam int RECORD_BITS   = RECORD_BYTES * 8;
    // CRC covers every byte except the trailer itself.
    localparam int CRC_DATA_BITS = RECORD_BITS - 8;

    // Byte positions; byte 0 goes out first.
    localparam int IDX_MAGIC_HI = 0;
    localparam int IDX_MAGIC_LO = 1;
    localparam int IDX_MAJOR    = 2;
    localparam int IDX_MINOR    = 3;
    localparam int IDX_PATCH    = 4;
    localparam int IDX_BUILD    = 5;
    localparam int IDX_YEAR_HI  = 6;
    localparam int IDX_YEAR_LO  = 7;
    localparam int IDX_MONTH    = 8;
    localparam int IDX_DAY      = 9;
    localparam int IDX_HOUR     = 10;
    localparam int IDX_MINUTE   = 11;
    localparam int IDX_SECOND   = 12;
    localparam int IDX_LENGTH   = 13;
    localparam int IDX_SEQ      = 14;
    localparam int IDX_TRAILER  = 15;

    localparam logic [7:0] RECORD_LEN = 8'(RECORD_BYTES);

    // CRC-8: poly x^8+x^2+x+1, MSB first, no reflection, no final XOR.
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Field order matches byte order, so bit 127 is the MSB of byte 0.
    typedef struct packed {
        logic [15:0] magic;
        logic [7:0]  major;
        logic [7:0]  minor;
        logic [7:0]  patch;
        logic [7:0]  build;
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  second;
        logic [7:0]  length;
        logic [7:0]  seq;
        logic [7:0]  trailer;
    } record_t;

    function automatic logic [RECORD_BITS-1:0] put_byte(
        input logic [RECORD_BITS-1:0] rec,
        input int                     idx,
        input logic [7:0]             value
    );
        logic [RECORD_BITS-1:0] result;
        result = rec;
        result[(RECORD_BYTES - 1 - idx) * 8 +: 8] = value;
        return result;
    endfunction

    function automatic record_t build_record(
        input logic [15:0] magic,
        input logic [7:0]  seq
    );
        logic [RECORD_BITS-1:0] r;
        r = '0;
        r = put_byte(r, IDX_MAGIC_HI, magic[15:8]);
        r = put_byte(r, IDX_MAGIC_LO, magic[7:0]);
        r = put_byte(r, IDX_MAJOR,    VER_MAJOR);
        r = put_byte(r, IDX_MINOR,    VER_MINOR);
        r = put_byte(r, IDX_PATCH,    VER_PATCH);
        r = put_byte(r, IDX_BUILD,    VER_BUILD);
        r = put_byte(r, IDX_YEAR_HI,  BUILD_YEAR[15:8]);
        r = put_byte(r, IDX_YEAR_LO,  BUILD_YEAR[7:0]);
        r = put_byte(r, IDX_MONTH,    BUILD_MONTH);
        r = put_byte(r, IDX_DAY,      BUILD_DAY);
        r = put_byte(r, IDX_HOUR,     BUILD_HOUR);
        r = put_byte(r, IDX_MINUTE,   BUILD_MINUTE);
        r = put_byte(r, IDX_SECOND,   BUILD_SECOND);
        r = put_byte(r, IDX_LENGTH,   RECORD_LEN);
        r = put_byte(r, IDX_SEQ,      seq);
        r = put_byte(r, IDX_TRAILER,  8'h00);
        return record_t'(r);
    endfunction

endpackage

// File: rtl/version_info_if.sv
// -----------------------------------------------------------------------------
// version_info_if
// Valid/ready beat stream carrying version-info records.
//   m_tdata  [DATA_W] : beat payload, earliest record byte in the MSBs
//   m_tvalid          : beat valid (source)
//   m_tready          : sink ready
//   m_tlast           : final beat of a record
// Modports: master (record source), slave (record sink).
// -----------------------------------------------------------------------------
interface version_info_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/version_info_crc8.sv
// -----------------------------------------------------------------------------
// version_info_crc8
// Combinational CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no
// final XOR) over the first 15 record bytes. Only exists when
// VERSION_INFO_CRC_EN is defined; without it the record trailer is a constant.
// Ports:
//   data_i [120] : record bytes 0..14, byte 0 in the MSBs
//   crc_o  [8]   : CRC-8 of data_i
// -----------------------------------------------------------------------------
`ifdef VERSION_INFO_CRC_EN
module version_info_crc8
    import version_info_pkg::*;
(
    input  logic [CRC_DATA_BITS-1:0] data_i,
    output logic [7:0]               crc_o
);
    // One shift/XOR stage per input bit, MSB of data_i first.
    logic [CRC_DATA_BITS:0][7:0] stage;

    assign stage[0] = CRC8_INIT;

    genvar gi;
    generate
        for (gi = 0; gi < CRC_DATA_BITS; gi++) begin : g_bit
            logic feedback;
            assign feedback      = stage[gi][7] ^ data_i[CRC_DATA_BITS - 1 - gi];
            assign stage[gi + 1] = {stage[gi][6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
        end
    endgenerate

    assign crc_o = stage[CRC_DATA_BITS];
endmodule
`endif

// File: rtl/version_info_streamer.sv
// -----------------------------------------------------------------------------
// version_info_streamer
// Snapshots the build version/date constants plus a running sequence number
// into a 16-byte record and streams it big-endian over a valid/ready beat
// interface. Sends start on req_i or, when REPEAT_PERIOD > 0, on a free-running
// timer. One further request can be queued while a record is in flight.
// Optional feature macro: VERSION_INFO_CRC_EN (trailer byte = CRC-8 of bytes
// 0..14; otherwise the trailer is 0x00).
// Parameters: DATA_W (8/16/32), MAGIC (record header), REPEAT_PERIOD (0 = off).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req_i     : single-cycle send request
//   busy_o    : record in flight or a request queued
//   seq_o     : sequence number the next record will carry
//   strm      : record beat stream (master side)
// -----------------------------------------------------------------------------
module version_info_streamer
    import version_info_pkg::*;
#(
    parameter int          DATA_W        = 8,
    parameter logic [15:0] MAGIC         = 16'hB1D0,
    parameter int          REPEAT_PERIOD = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_i,
    output logic           busy_o,
    output logic [7:0]     seq_o,
    version_info_if.master strm
);

    localparam int             BEATS        = RECORD_BITS / DATA_W;
    localparam int             CNT_W        = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BUT_ONE = CNT_W'(BEATS - 2);

    generate
        if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
            $error("version_info_streamer: DATA_W must be 8, 16 or 32");
        end
    endgenerate

    state_t                 state_q;
    logic                   pending_q;
    logic [RECORD_BITS-1:0] shift_q;
    logic [CNT_W-1:0]       beat_q;
    logic [7:0]             seq_q;
    logic                   tvalid_q;
    logic                   tlast_q;

    logic                   timer_expire;
    logic                   new_req;
    logic                   beat_accept;
    logic [7:0]             snap_seq;
    record_t                snap_base;
    record_t                snap_rec;
    logic [7:0]             trailer_byte;

    // ------------------------------------------------------------------
    // Periodic send timer
    // ------------------------------------------------------------------
    generate
        if (REPEAT_PERIOD > 0) begin : g_timer
            localparam int            TW       = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
            localparam logic [TW-1:0] TERMINAL = TW'(REPEAT_PERIOD - 1);

            logic [TW-1:0] count_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else if (count_q == TERMINAL) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_q + TW'(1);
                end
            end

            assign timer_expire = (count_q == TERMINAL);
        end else begin : g_no_timer
            assign timer_expire = 1'b0;
        end
    endgenerate

    // A request and a timer expiry in the same cycle are one request.
    assign new_req     = req_i || timer_expire;
    assign beat_accept = tvalid_q && strm.m_tready;

    // ------------------------------------------------------------------
    // Record snapshot. From SEND the only load is the back-to-back restart
    // on the last beat, which must already carry the incremented sequence.
    // ------------------------------------------------------------------
    assign snap_seq  = (state_q == SEND) ? seq_q + 8'd1 : seq_q;
    assign snap_base = build_record(MAGIC, snap_seq);

`ifdef VERSION_INFO_CRC_EN
    version_info_crc8 u_crc8 (
        .data_i (snap_base[RECORD_BITS-1:8]),
        .crc_o  (trailer_byte)
    );
`else
    assign trailer_byte = 8'h00;
`endif

    always_comb begin
        snap_rec         = snap_base;
        snap_rec.trailer = trailer_byte;
    end

    // ------------------------------------------------------------------
    // Send FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            shift_q   <= '0;
            beat_q    <= '0;
            seq_q     <= 8'h00;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i || pending_q) begin
                        // Any coincident expiry is absorbed into this send.
                        state_q   <= SEND;
                        pending_q <= 1'b0;
                        shift_q   <= snap_rec;
                        beat_q    <= '0;
                        tvalid_q  <= 1'b1;
                        tlast_q   <= 1'b0;
                    end else if (timer_expire) begin
                        pending_q <= 1'b1;
                    end
                end

                SEND: begin
                    if (beat_accept && tlast_q) begin
                        seq_q <= seq_q + 8'd1;
                        if (pending_q || new_req) begin
                            // Restart with no idle bubble.
                            pending_q <= 1'b0;
                            shift_q   <= snap_rec;
                            beat_q    <= '0;
                            tlast_q   <= 1'b0;
                        end else begin
                            state_q   <= IDLE;
                            shift_q   <= '0;
                            tvalid_q  <= 1'b0;
                            tlast_q   <= 1'b0;
                        end
                    end else begin
                        if (beat_accept) begin
                            shift_q <= {shift_q[RECORD_BITS-DATA_W-1:0], {DATA_W{1'b0}}};
                            beat_q  <= beat_q + CNT_W'(1);
                            tlast_q <= (beat_q == LAST_BUT_ONE);
                        end
                        // Queue at most one; extra requests are dropped.
                        if (new_req) begin
                            pending_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign strm.m_tdata  = shift_q[RECORD_BITS-1 -: DATA_W];
    assign strm.m_tvalid = tvalid_q;
    assign strm.m_tlast  = tlast_q;
    assign busy_o        = (state_q == SEND) || pending_q;
    assign seq_o         = seq_q;

endmodule

// File: doc/version_info_streamer.md
# version_info_streamer

Parametrised successor to the static build-version constants. Snapshots the build version/date constants plus a running sequence number into a fixed 16-byte record and streams it over a valid/ready byte-stream interface of configurable width. Sends happen on request, or periodically from an internal timer. It sits beside the debug/telemetry path so the host can identify the running bitstream without register reads.

## Interface
- DATA_W, 8: output beat width in bits; legal values are 8, 16 and 32. Other values raise an elaboration error.
- MAGIC, 16'hB1D0: 16-bit record header.
- REPEAT_PERIOD, 0: cycles between automatic sends. 0 disables the timer.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  single-cycle send request.
- busy_o  out  1  high while a record is in flight or pending.
- m_tdata  out  DATA_W  record beat. The earliest byte is in the MSBs, so packing is big-endian.
- m_tvalid  out  1  beat valid.
- m_tready  in  1  sink ready.
- m_tlast  out  1  marks the final beat of a record.
- seq_o  out  8  sequence number of the next record to be sent.

## Operation
- Record layout, bytes 0..15:
  - Bytes 0..1: MAGIC, high byte first.
  - Bytes 2..5: major, minor, patch, build.
  - Bytes 6..7: year, BCD, high byte first.
  - Bytes 8..12: month, day, hour, minute, second, all BCD.
  - Byte 13: record length, 0x10.
  - Byte 14: sequence number.
  - Byte 15: trailer (see Configuration).
- The state machine has two states: IDLE and SEND.
- A one-deep `pending` flag holds a request that cannot start yet.
  - It is set by req_i, or by timer expiry, or by both in the same cycle. Either way it is one request.
  - Requests arriving while pending is already set are dropped.
- IDLE -> SEND when req_i or pending is set.
  - On entry, snapshot the full record into the shift register, using the current seq.
  - Clear pending.
- In SEND, each beat is accepted when m_tvalid && m_tready. The block then shifts by DATA_W and counts the beat.
- Beats per record = 16 / (DATA_W/8), giving 16, 8 or 4 beats.
- When the last beat is accepted:
  - seq increments, wrapping 0xFF -> 0x00.
  - If pending or req_i is set, go straight to SEND again with a fresh snapshot. There is no idle bubble.
  - Otherwise return to IDLE.
- A request arriving during SEND sets pending. It never corrupts the record in flight.
- Timer (REPEAT_PERIOD > 0):
  - Counts 0..REPEAT_PERIOD-1 continuously, including while SEND is active.
  - Expiry is the cycle the count equals REPEAT_PERIOD-1. On expiry the count reloads to 0 and pending is set.
- busy_o = (state == SEND) || pending.

## Timing
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, busy_o=0, seq_o=0.
  - State IDLE, pending=0, timer count 0.
- Reset mid-record aborts immediately. No further beats are emitted, and the partial record is not resumed after reset.
- Latency: req_i in cycle n puts the first beat on m_tvalid in cycle n+1. All outputs are registered.
- m_tvalid never deasserts before acceptance. m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
- m_tlast is high only on the final beat.
- With m_tready held high, a record occupies exactly beats-per-record consecutive cycles.
- seq_o updates in the cycle after the last beat is accepted.

## Configuration
- VERSION_INFO_CRC_EN defined:
  - Byte 15 = CRC-8 over bytes 0..14.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - The CRC is computed at snapshot time, because seq varies per record.
- VERSION_INFO_CRC_EN undefined: byte 15 = 0x00, and no CRC logic is instantiated.

## Structure
- The shared package version_info_pkg holds:
  - The RECORD_BYTES=16 constant.
  - The byte-index localparams.
  - The state enum {IDLE, SEND}.
  - The CRC-8 constants.
  - The record type, a 128-bit packed struct.
- The package imports the existing version constants package for the version and date fields.
- Sub-module version_info_crc8: combinational CRC-8 over a 120-bit input. Instantiated only under VERSION_INFO_CRC_EN.

## Test plan
- Record bytes with DATA_W=8, CRC off, MAGIC 16'hB1D0, build 64, 2025-11-08 15:03:23, one req_i, m_tready=1:
  - 16 beats: B1 D0 00 00 00 40 20 25 11 08 15 03 23 10 00 00.
  - m_tlast on beat 16 only.
  - seq_o reaches 0x01 afterwards.
- Beat packing with DATA_W=32, same build: 4 beats 0xB1D00000, 0x00402025, 0x11081503, 0x23100000.
- Backpressure: toggle m_tready pseudo-randomly. m_tdata must hold across stalls, and no beat may be lost or duplicated.
- Back-to-back requests:
  - A second req_i mid-record sends a second record with byte 14 = 0x01, with no idle cycle in between.
  - A third req_i in the same record is dropped.
- Timer and wrap:
  - REPEAT_PERIOD=40 and DATA_W=8 give a record every 40 cycles.
  - A req_i coinciding with expiry yields exactly one extra record.
  - After 256 records, seq wraps to 0x00.
- Reset and CRC:
  - Assert rst on beat 5: m_tvalid drops to 0 asynchronously and seq_o=0; the next req_i restarts at byte 0.
  - With VERSION_INFO_CRC_EN, byte 15 must match the bench's CRC-8 model for every sequence value 0..255.
